// File: rtl/pcileech_bar_arb_pkg.sv
// Shared types and helpers for the two-requester BAR port arbiter.
package pcileech_bar_arb_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, QUIESCED} arb_state_t;

    localparam int unsigned REQ_HOST = 0;
    localparam int unsigned REQ_INT  = 1;

    // One-hot grant between two requesters; ptr selects the winner when both are valid.
    function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic ptr);
        logic [1:0] gnt;
        case (valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/pcileech_bar_port_arbiter_if.sv
// Requester-side and BAR-side signals of the arbiter; slave is the arbiter's view.
interface pcileech_bar_port_arbiter_if #(
    parameter int unsigned CTX_W = 88
);
    logic [1:0][31:0]      rq_wr_addr;
    logic [1:0][3:0]       rq_wr_be;
    logic [1:0][31:0]      rq_wr_data;
    logic [1:0]            rq_wr_valid;
    logic [1:0]            rq_wr_ready;
    logic [1:0][CTX_W-1:0] rq_rd_ctx;
    logic [1:0][31:0]      rq_rd_addr;
    logic [1:0]            rq_rd_valid;
    logic [1:0]            rq_rd_ready;
    logic [1:0][CTX_W-1:0] rq_rsp_ctx;
    logic [1:0][31:0]      rq_rsp_data;
    logic [1:0]            rq_rsp_valid;

    logic [31:0]           bar_wr_addr;
    logic [3:0]            bar_wr_be;
    logic [31:0]           bar_wr_data;
    logic                  bar_wr_valid;
    logic [CTX_W-1:0]      bar_rd_req_ctx;
    logic [31:0]           bar_rd_req_addr;
    logic                  bar_rd_req_valid;
    logic [CTX_W-1:0]      bar_rd_rsp_ctx;
    logic [31:0]           bar_rd_rsp_data;
    logic                  bar_rd_rsp_valid;

    modport slave (
        input  rq_wr_addr, rq_wr_be, rq_wr_data, rq_wr_valid,
        output rq_wr_ready,
        input  rq_rd_ctx, rq_rd_addr, rq_rd_valid,
        output rq_rd_ready,
        output rq_rsp_ctx, rq_rsp_data, rq_rsp_valid,
        output bar_wr_addr, bar_wr_be, bar_wr_data, bar_wr_valid,
        output bar_rd_req_ctx, bar_rd_req_addr, bar_rd_req_valid,
        input  bar_rd_rsp_ctx, bar_rd_rsp_data, bar_rd_rsp_valid
    );

    modport master (
        output rq_wr_addr, rq_wr_be, rq_wr_data, rq_wr_valid,
        input  rq_wr_ready,
        output rq_rd_ctx, rq_rd_addr, rq_rd_valid,
        input  rq_rd_ready,
        input  rq_rsp_ctx, rq_rsp_data, rq_rsp_valid,
        input  bar_wr_addr, bar_wr_be, bar_wr_data, bar_wr_valid,
        input  bar_rd_req_ctx, bar_rd_req_addr, bar_rd_req_valid,
        output bar_rd_rsp_ctx, bar_rd_rsp_data, bar_rd_rsp_valid
    );

endinterface

// File: rtl/pcileech_bar_owner_fifo.sv
// 1-bit owner-id FIFO recording which requester issued each outstanding BAR read.
module pcileech_bar_owner_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   push_id,
    input  logic                   pop,
    output logic                   head_id,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = count_q[PW];
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem_q[rptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_id;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcileech_bar_port_arbiter.sv
// Shares one BAR write port and one 2-cycle read port between the TLP dispatcher and
// an internal engine, with reply routing and a quiesce handshake.
module pcileech_bar_port_arbiter
    import pcileech_bar_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CTX_W           = 88
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pcileech_bar_port_arbiter_if.slave  bus,
    input  logic                        quiesce_req,
    output logic                        quiesce_ack,
    output logic                        err_orphan_rsp
);
    arb_state_t state_q, state_d;
    logic       run;
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] wr_gnt, rd_cand, rd_gnt;
    logic       wr_sel, rd_sel, hazard;

    logic                           fifo_full, fifo_empty, fifo_head, fifo_pop;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;

    logic [31:0]           bar_wr_addr_q, bar_wr_data_q, bar_rd_req_addr_q;
    logic [3:0]            bar_wr_be_q;
    logic                  bar_wr_valid_q, bar_rd_req_valid_q;
    logic [CTX_W-1:0]      bar_rd_req_ctx_q;
    logic [1:0][CTX_W-1:0] rsp_ctx_q;
    logic [1:0][31:0]      rsp_data_q;
    logic [1:0]            rsp_valid_q;
    logic                  err_q;

    assign run = (state_q == RUN);

    // A read aimed at the word being written this cycle waits one cycle to see the new data.
    always_comb begin
        wr_gnt  = run ? rr_grant(bus.rq_wr_valid, wr_ptr_q) : 2'b00;
        wr_sel  = wr_gnt[1];
        rd_cand = rr_grant(bus.rq_rd_valid, rd_ptr_q);
        rd_sel  = rd_cand[1];
        hazard  = (wr_gnt != 2'b00) &&
                  (bus.rq_wr_addr[wr_sel][11:2] == bus.rq_rd_addr[rd_sel][11:2]);
        rd_gnt  = (run && !fifo_full && !hazard) ? rd_cand : 2'b00;
    end

    assign bus.rq_wr_ready = wr_gnt;
    assign bus.rq_rd_ready = rd_gnt;
    assign fifo_pop        = bus.bar_rd_rsp_valid && !fifo_empty;

    pcileech_bar_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rd_gnt != 2'b00),
        .push_id (rd_gnt[REQ_INT]),
        .pop     (fifo_pop),
        .head_id (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q           <= 1'(REQ_HOST);
            rd_ptr_q           <= 1'(REQ_HOST);
            bar_wr_valid_q     <= 1'b0;
            bar_wr_addr_q      <= '0;
            bar_wr_be_q        <= '0;
            bar_wr_data_q      <= '0;
            bar_rd_req_valid_q <= 1'b0;
            bar_rd_req_addr_q  <= '0;
            bar_rd_req_ctx_q   <= '0;
        end else begin
            bar_wr_valid_q     <= (wr_gnt != 2'b00);
            bar_rd_req_valid_q <= (rd_gnt != 2'b00);
            if (wr_gnt != 2'b00) begin
                bar_wr_addr_q <= bus.rq_wr_addr[wr_sel];
                bar_wr_be_q   <= bus.rq_wr_be[wr_sel];
                bar_wr_data_q <= bus.rq_wr_data[wr_sel];
                if (bus.rq_wr_valid == 2'b11) begin
                    wr_ptr_q <= ~wr_sel;
                end
            end
            if (rd_gnt != 2'b00) begin
                bar_rd_req_addr_q <= bus.rq_rd_addr[rd_sel];
                bar_rd_req_ctx_q  <= bus.rq_rd_ctx[rd_sel];
                if (bus.rq_rd_valid == 2'b11) begin
                    rd_ptr_q <= ~rd_sel;
                end
            end
        end
    end

    // Replies are routed in every FSM state; an empty FIFO means nobody owns the reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_ctx_q   <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (fifo_pop) begin
                rsp_valid_q[fifo_head] <= 1'b1;
                rsp_ctx_q[fifo_head]   <= bus.bar_rd_rsp_ctx;
                rsp_data_q[fifo_head]  <= bus.bar_rd_rsp_data;
            end
            if (bus.bar_rd_rsp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (quiesce_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!quiesce_req) begin
                    state_d = RUN;
                end else if (fifo_count == '0 && !bar_wr_valid_q && !bar_rd_req_valid_q) begin
                    state_d = QUIESCED;
                end
            end
            QUIESCED: begin
                if (!quiesce_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign quiesce_ack          = (state_q == QUIESCED);
    assign err_orphan_rsp       = err_q;
    assign bus.bar_wr_addr      = bar_wr_addr_q;
    assign bus.bar_wr_be        = bar_wr_be_q;
    assign bus.bar_wr_data      = bar_wr_data_q;
    assign bus.bar_wr_valid     = bar_wr_valid_q;
    assign bus.bar_rd_req_addr  = bar_rd_req_addr_q;
    assign bus.bar_rd_req_ctx   = bar_rd_req_ctx_q;
    assign bus.bar_rd_req_valid = bar_rd_req_valid_q;
    assign bus.rq_rsp_valid     = rsp_valid_q;
    assign bus.rq_rsp_ctx       = rsp_ctx_q;
    assign bus.rq_rsp_data      = rsp_data_q;

endmodule

// File: tb/tb_pcileech_bar_port_arbiter.sv
// Directed bench for the BAR port arbiter with a 2-cycle BAR model and a reply scoreboard.
module tb_pcileech_bar_port_arbiter;
    localparam int unsigned CTX_W = 88;
    localparam int unsigned MAXO  = 4;

    typedef struct {
        logic [CTX_W-1:0] ctx;
        logic [31:0]      data;
        int               due;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic quiesce_req = 1'b0;
    logic quiesce_ack, err_orphan_rsp;

    pcileech_bar_port_arbiter_if #(.CTX_W(CTX_W)) bus ();

    pcileech_bar_port_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .CTX_W           (CTX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .quiesce_req    (quiesce_req),
        .quiesce_ack    (quiesce_ack),
        .err_orphan_rsp (err_orphan_rsp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [9:0] w);
        return {16'hB00B, 6'h00, w};
    endfunction

    // BAR model: word-addressed memory, replies two cycles after the request, optional stall.
    bit          stall = 1'b0;
    bit          inject = 1'b0;
    logic [31:0] mem [1024];
    bit          written [1024];
    item_t       bar_q[$];

    always @(posedge clk) begin
        item_t it;
        logic [9:0] w;
        bus.bar_rd_rsp_valid <= inject;
        bus.bar_rd_rsp_ctx   <= {CTX_W{1'b1}};
        bus.bar_rd_rsp_data  <= 32'hBAD0BAD0;
        if (!stall && bar_q.size() > 0 && bar_q[0].due <= cyc) begin
            it = bar_q.pop_front();
            bus.bar_rd_rsp_valid <= 1'b1;
            bus.bar_rd_rsp_ctx   <= it.ctx;
            bus.bar_rd_rsp_data  <= it.data;
        end
        if (bus.bar_rd_req_valid) begin
            w       = bus.bar_rd_req_addr[11:2];
            it.ctx  = bus.bar_rd_req_ctx;
            it.data = written[w] ? mem[w] : pat(w);
            it.due  = cyc + 1;
            bar_q.push_back(it);
        end
        if (bus.bar_wr_valid) begin
            w = bus.bar_wr_addr[11:2];
            for (int b = 0; b < 4; b++) begin
                if (bus.bar_wr_be[b]) mem[w][8*b +: 8] <= bus.bar_wr_data[8*b +: 8];
            end
            written[w] <= 1'b1;
        end
    end

    // Accepted reads push their hand-computed reply into the owner's expectation queue.
    item_t       exp_q0[$];
    item_t       exp_q1[$];
    logic [31:0] rd_exp [2];
    bit          rd_lat [2];
    int          acc_cyc [2];

    always @(negedge clk) begin
        item_t e;
        #1;
        for (int r = 0; r < 2; r++) begin
            if (rst_n && bus.rq_rd_valid[r] && bus.rq_rd_ready[r]) begin
                e.ctx  = bus.rq_rd_ctx[r];
                e.data = rd_exp[r];
                e.due  = rd_lat[r] ? cyc + 4 : 0;
                if (r == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                acc_cyc[r] = cyc;
            end
        end
    end

    always @(negedge clk) begin
        item_t e;
        bit    have;
        if (rst_n) begin
            if (bus.rq_rsp_valid == 2'b11) begin
                n_checks++;
                n_errors++;
                $display("FAIL rsp_both: got rsp_valid=0x3, want at most one");
            end
            for (int r = 0; r < 2; r++) begin
                if (bus.rq_rsp_valid[r]) begin
                    have = (r == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                    if (!have) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rsp%0d_unexpected: got reply data 0x%0h, want none",
                                 r, bus.rq_rsp_data[r]);
                    end else begin
                        e = (r == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("rsp%0d_ctx", r), bus.rq_rsp_ctx[r], e.ctx);
                        check($sformatf("rsp%0d_data", r), bus.rq_rsp_data[r], e.data);
                        if (e.due != 0) check($sformatf("rsp%0d_latency", r), cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want run to complete");
        $fatal(1, "watchdog");
    end

    task automatic set_rd(input int r, input logic [31:0] addr, input logic [CTX_W-1:0] ctx,
                          input logic [31:0] exp, input bit lat);
        bus.rq_rd_valid[r] = 1'b1;
        bus.rq_rd_addr[r]  = addr;
        bus.rq_rd_ctx[r]   = ctx;
        rd_exp[r]          = exp;
        rd_lat[r]          = lat;
    endtask

    logic [1:0]  exp_wr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] exp_wa [4] = '{32'h10, 32'h20, 32'h10, 32'h20};
    logic [31:0] exp_wd [4] = '{32'h1111_0010, 32'h2222_0020, 32'h1111_0010, 32'h2222_0020};
    int k, t_hz, first_rsp, acc5, nrsp, r3, ack_cyc;

    initial begin
        bus.rq_wr_addr  = '0;
        bus.rq_wr_be    = '0;
        bus.rq_wr_data  = '0;
        bus.rq_wr_valid = '0;
        bus.rq_rd_ctx   = '0;
        bus.rq_rd_addr  = '0;
        bus.rq_rd_valid = '0;
        rd_lat          = '{1'b0, 1'b0};
        rd_exp          = '{32'h0, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_err", err_orphan_rsp, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("rst_bar_wr_valid", bus.bar_wr_valid, 1'b0);
        check("rst_bar_rd_valid", bus.bar_rd_req_valid, 1'b0);
        check("rst_bar_wr_addr", bus.bar_wr_addr, 32'h0);
        check("rst_rsp_valid", bus.rq_rsp_valid, 2'b00);
        check("rst_rsp_ctx0", bus.rq_rsp_ctx[0], '0);
        check("rst_ack", quiesce_ack, 1'b0);

        // Both requesters write continuously: grants alternate starting with requester 0
        @(negedge clk);
        bus.rq_wr_addr  = {32'h20, 32'h10};
        bus.rq_wr_data  = {32'h2222_0020, 32'h1111_0010};
        bus.rq_wr_be    = {4'hF, 4'hF};
        bus.rq_wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("wr_ready_%0d", i), bus.rq_wr_ready, exp_wr[i]);
            @(negedge clk);
            if (i == 3) bus.rq_wr_valid = 2'b00;
            check($sformatf("bar_wr_valid_%0d", i), bus.bar_wr_valid, 1'b1);
            check($sformatf("bar_wr_addr_%0d", i), bus.bar_wr_addr, exp_wa[i]);
            check($sformatf("bar_wr_data_%0d", i), bus.bar_wr_data, exp_wd[i]);
        end
        repeat (2) @(negedge clk);

        // Staggered reads from both requesters, exact 4/5-cycle reply latency
        set_rd(0, 32'h04, 88'hAA, 32'hB00B_0001, 1'b1);
        #2;
        check("t2_rd0_ready", bus.rq_rd_ready[0], 1'b1);
        @(negedge clk);
        bus.rq_rd_valid[0] = 1'b0;
        set_rd(1, 32'h08, 88'hBB, 32'hB00B_0002, 1'b1);
        #2;
        check("t2_rd1_ready", bus.rq_rd_ready[1], 1'b1);
        check("t2_bar_rd_valid", bus.bar_rd_req_valid, 1'b1);
        check("t2_bar_rd_addr", bus.bar_rd_req_addr, 32'h04);
        check("t2_bar_rd_ctx", bus.bar_rd_req_ctx, 88'hAA);
        @(negedge clk);
        bus.rq_rd_valid[1] = 1'b0;
        #2;
        check("t2_bar_rd_addr2", bus.bar_rd_req_addr, 32'h08);
        repeat (8) @(negedge clk);

        // Six back-to-back reads against a stalled BAR: only MAXO are accepted
        stall = 1'b1;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            set_rd(1, 32'h40 + 32'(4 * k), 88'(32'h100 + k), pat(10'(16 + k)), 1'b0);
            #2;
            if (bus.rq_rd_ready[1]) k++;
        end
        check("t3_accepted", k, 4);
        check("t3_ready_full", bus.rq_rd_ready[1], 1'b0);
        first_rsp = -1;
        acc5 = -1;
        for (int i = 0; i < 20 && k < 6; i++) begin
            @(negedge clk);
            stall = 1'b0;
            set_rd(1, 32'h40 + 32'(4 * k), 88'(32'h100 + k), pat(10'(16 + k)), 1'b0);
            #2;
            if (bus.bar_rd_rsp_valid && first_rsp < 0) first_rsp = cyc;
            if (bus.rq_rd_ready[1]) begin
                k++;
                if (k == 5) acc5 = cyc;
            end
        end
        check("t3_all_accepted", k, 6);
        check("t3_fifth_after_pop", acc5, first_rsp + 1);
        @(negedge clk);
        bus.rq_rd_valid[1] = 1'b0;
        repeat (12) @(negedge clk);

        // Same-word write and read in one cycle: read slips a cycle and sees the new data
        bus.rq_wr_valid[0] = 1'b1;
        bus.rq_wr_addr[0]  = 32'h0C;
        bus.rq_wr_data[0]  = 32'hDEADBEEF;
        bus.rq_wr_be[0]    = 4'hF;
        set_rd(1, 32'h0C, 88'hCC, 32'hDEADBEEF, 1'b1);
        #2;
        t_hz = cyc;
        check("t4_wr_ready", bus.rq_wr_ready, 2'b01);
        check("t4_rd_blocked", bus.rq_rd_ready[1], 1'b0);
        @(negedge clk);
        bus.rq_wr_valid[0] = 1'b0;
        #2;
        check("t4_rd_ready", bus.rq_rd_ready[1], 1'b1);
        check("t4_accept_cycle", acc_cyc[1], t_hz + 1);
        @(negedge clk);
        bus.rq_rd_valid[1] = 1'b0;
        repeat (8) @(negedge clk);

        // Quiesce with three reads outstanding
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rd(0, 32'h200 + 32'(4 * i), 88'(32'h300 + i), pat(10'(128 + i)), 1'b0);
            #2;
            check($sformatf("t5_rd_ready_%0d", i), bus.rq_rd_ready[0], 1'b1);
            @(negedge clk);
        end
        bus.rq_rd_valid[0] = 1'b0;
        quiesce_req = 1'b1;
        @(negedge clk);
        set_rd(0, 32'h20C, 88'h3FF, pat(10'd131), 1'b0);
        bus.rq_wr_valid[1] = 1'b1;
        bus.rq_wr_addr[1]  = 32'h300;
        bus.rq_wr_data[1]  = 32'h3333_0300;
        bus.rq_wr_be[1]    = 4'hF;
        #2;
        check("t5_rd_ready_drain", bus.rq_rd_ready, 2'b00);
        check("t5_wr_ready_drain", bus.rq_wr_ready, 2'b00);
        check("t5_ack_drain", quiesce_ack, 1'b0);
        nrsp = 0;
        r3 = -1;
        ack_cyc = -1;
        for (int i = 0; i < 20 && ack_cyc < 0; i++) begin
            @(negedge clk);
            stall = 1'b0;
            #2;
            if (bus.bar_rd_rsp_valid) begin
                nrsp++;
                if (nrsp == 3) r3 = cyc;
            end
            if (quiesce_ack && ack_cyc < 0) ack_cyc = cyc;
        end
        check("t5_ack_after_third", ack_cyc, r3 + 2);
        check("t5_rd_ready_quiesced", bus.rq_rd_ready, 2'b00);
        @(negedge clk);
        quiesce_req = 1'b0;
        #2;
        check("t5_ack_hold", quiesce_ack, 1'b1);
        @(negedge clk);
        rd_lat[0] = 1'b1;
        #2;
        check("t5_ack_dropped", quiesce_ack, 1'b0);
        check("t5_rd_resume", bus.rq_rd_ready[0], 1'b1);
        check("t5_wr_resume", bus.rq_wr_ready, 2'b10);
        @(negedge clk);
        bus.rq_rd_valid[0] = 1'b0;
        bus.rq_wr_valid[1] = 1'b0;
        repeat (8) @(negedge clk);

        // Orphan reply with an empty owner FIFO
        check("t6_err_before", err_orphan_rsp, 1'b0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        @(negedge clk);
        #2;
        check("t6_err_set", err_orphan_rsp, 1'b1);
        check("t6_no_rsp", bus.rq_rsp_valid, 2'b00);
        repeat (3) @(negedge clk);
        #2;
        check("t6_err_sticky", err_orphan_rsp, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_err_async_clear", err_orphan_rsp, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("t6_err_after_reset", err_orphan_rsp, 1'b0);

        check("sb_q0_empty", exp_q0.size(), 0);
        check("sb_q1_empty", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pcileech_bar_port_arbiter.md
Name: pcileech_bar_port_arbiter

Overview:
- Shares one 4 kB BAR implementation (write port plus 2-CLK read port, ctx passthrough) between two requesters.
- Requester 0 is the TLP BAR dispatcher. Requester 1 is an internal engine, for example a BAR preload or scrub engine.
- Arbitrates writes and reads independently, tracks outstanding reads, and routes read replies back to their owner.
- Provides a quiesce handshake so firmware can freeze BAR traffic, for example before swapping the BAR response strategy.

Parameters:
- MAX_OUTSTANDING, 4: owner-FIFO depth, i.e. the maximum number of reads in flight to the BAR. Power of 2, range 2..16.
- CTX_W, 88: width of the read context.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rq_wr_addr[0:1]  in  32 each  requester write address.
- rq_wr_be[0:1]  in  4 each  byte enables.
- rq_wr_data[0:1]  in  32 each  write data.
- rq_wr_valid[0:1]  in  1 each  write request.
- rq_wr_ready[0:1]  out  1 each  write accepted when valid and ready are both high.
- rq_rd_ctx[0:1]  in  CTX_W each  read context.
- rq_rd_addr[0:1]  in  32 each  read address.
- rq_rd_valid[0:1]  in  1 each  read request.
- rq_rd_ready[0:1]  out  1 each  read accepted.
- rq_rsp_ctx[0:1]  out  CTX_W each  reply context.
- rq_rsp_data[0:1]  out  32 each  reply data.
- rq_rsp_valid[0:1]  out  1 each  one-cycle reply strobe; no backpressure.
- bar_wr_addr  out  32  to BAR.
- bar_wr_be  out  4  to BAR.
- bar_wr_data  out  32  to BAR.
- bar_wr_valid  out  1  to BAR.
- bar_rd_req_ctx  out  CTX_W  to BAR.
- bar_rd_req_addr  out  32  to BAR.
- bar_rd_req_valid  out  1  to BAR.
- bar_rd_rsp_ctx  in  CTX_W  from BAR.
- bar_rd_rsp_data  in  32  from BAR.
- bar_rd_rsp_valid  in  1  from BAR.
- quiesce_req  in  1  level request to freeze new grants.
- quiesce_ack  out  1  high while frozen and fully drained.
- err_orphan_rsp  out  1  sticky: a reply arrived with the owner FIFO empty.

Behaviour:
- Reset (async assert, sync release): all bar_* valids 0; all rq_rsp_valid 0; data and ctx outputs 0; owner FIFO empty, count 0; both round-robin pointers set to requester 0; FSM in RUN; quiesce_ack 0; err_orphan_rsp 0.
- Reset asserted mid-operation discards in-flight reads. BAR replies arriving after reset release with the FIFO empty set err_orphan_rsp.
- Ready signals are combinational from valid, pointer, FSM state and FIFO count. All bar_* outputs and all rq_rsp_* outputs are registered.
- Write channel:
  - In RUN, at most one write is granted per cycle.
  - If both requesters are valid, grant the one selected by wr_rr_ptr, then set the pointer to the other requester.
  - If only one is valid, grant it; the pointer is unchanged.
  - The granted write appears on bar_wr_* on the next cycle with bar_wr_valid=1.
- Read channel:
  - Same round-robin arbitration, using its own rd_rr_ptr.
  - A grant additionally requires fifo_count < MAX_OUTSTANDING, using the registered count.
  - A grant pushes the owner id into the owner FIFO and registers ctx and addr onto bar_rd_req_* on the next cycle.
- Read-during-write hazard:
  - If this cycle's write grant and read candidate have equal addr[11:2], the read is not granted (rq_rd_ready=0) that cycle.
  - The write proceeds. The read is granted the next cycle if still valid, so it observes the written data.
- Reply routing:
  - On bar_rd_rsp_valid, pop the FIFO head id h.
  - Next cycle: rq_rsp_valid[h]=1, with ctx and data copied from the BAR reply. The other requester's rsp_valid stays 0.
  - A reply with the FIFO empty: no pop, no output, err_orphan_rsp set until reset.
  - Push and pop in the same cycle leave the count unchanged. The FIFO pointers wrap modulo MAX_OUTSTANDING.
- Latency: read accepted at cycle T, bar_rd_req_valid at T+1, BAR reply at T+3, rq_rsp_valid at T+4.
- FSM:
  - RUN → DRAIN when quiesce_req=1.
  - DRAIN: all readies 0. DRAIN → QUIESCED when fifo_count==0 and no bar_*_valid is pending.
  - QUIESCED: quiesce_ack=1, readies 0.
  - QUIESCED → RUN when quiesce_req=0; ack drops in the same transition.
  - DRAIN → RUN directly if quiesce_req falls before the drain completes.
  - Replies are still routed in every state.

Decomposition:
- Shared package pcileech_bar_arb_pkg holds:
  - typedef arb_state_t {RUN, DRAIN, QUIESCED};
  - localparam REQ_HOST=0, REQ_INT=1;
  - a function for round-robin grant.
- One sub-module, pcileech_bar_owner_fifo: a 1-bit-wide sync FIFO with depth MAX_OUTSTANDING, push, pop, count, full and empty outputs.

Test Plan:
- Both requesters write continuously, to 0x10 and 0x20 → bar_wr alternates 0,1,0,1 starting with requester 0 after reset; no cycle has two writes.
- Req0 reads 0x04 with ctx 0xAA, req1 reads 0x08 one cycle later, BAR model with 2-CLK latency → rq_rsp_valid[0] at T+4 with ctx 0xAA, rq_rsp_valid[1] at T+5; no cross-delivery.
- Req1 issues 6 back-to-back reads and the BAR model stalls replies → exactly 4 granted, rq_rd_ready[1]=0 until the first reply pops, then the 5th is granted.
- Same-cycle write of 0xDEADBEEF to 0x0C by req0 and read of 0x0C by req1 → read is delayed 1 cycle and its reply data is 0xDEADBEEF.
- quiesce_req raised with 3 reads in flight → readies drop next cycle; quiesce_ack=1 only after the 3rd reply; drop quiesce_req → ack=0 and grants resume.
- Inject bar_rd_rsp_valid with the FIFO empty → err_orphan_rsp=1, no rq_rsp_valid pulse; only async rst_n clears it.
